// File: rtl/multicycle_control_fsm_if.sv
`default_nettype none
// ============================================================================
// Module : multicycle_control_fsm_if
// Desc   : Instruction-field inputs and datapath control outputs of the
//          multicycle control FSM.
// Rev    : 1.0
// ============================================================================
interface multicycle_control_fsm_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic       RegWrite;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;
  logic       illegal_op;

  modport master (
    output op, funct3, funct7b5, zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           RegWrite, ImmSrc, ALUControl, illegal_op
  );

  modport slave (
    input  op, funct3, funct7b5, zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           RegWrite, ImmSrc, ALUControl, illegal_op
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_control_fsm.sv
`default_nettype none
// ============================================================================
// Module : multicycle_control_fsm
// Desc   : Multicycle RISC-V control unit: state sequencing, mux selects,
//          write enables and ALU control decode.
// Rev    : 1.0
// ============================================================================
module multicycle_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  multicycle_control_fsm_if.slave bus,
  output logic [STATE_W-1:0]      state
);

  localparam logic [STATE_W-1:0] S_FETCH    = STATE_W'(0);
  localparam logic [STATE_W-1:0] S_DECODE   = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MEMADR   = STATE_W'(2);
  localparam logic [STATE_W-1:0] S_MEMREAD  = STATE_W'(3);
  localparam logic [STATE_W-1:0] S_MEMWB    = STATE_W'(4);
  localparam logic [STATE_W-1:0] S_MEMWRITE = STATE_W'(5);
  localparam logic [STATE_W-1:0] S_EXECR    = STATE_W'(6);
  localparam logic [STATE_W-1:0] S_EXECI    = STATE_W'(7);
  localparam logic [STATE_W-1:0] S_ALUWB    = STATE_W'(8);
  localparam logic [STATE_W-1:0] S_BEQ      = STATE_W'(9);
  localparam logic [STATE_W-1:0] S_JAL      = STATE_W'(10);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  logic [STATE_W-1:0] r_state;
  logic [STATE_W-1:0] w_next;
  logic [1:0]         w_aluop;
  logic               w_pcwrite, w_memwrite, w_irwrite, w_regwrite, w_illegal;
  logic               w_adrsrc;
  logic [1:0]         w_resultsrc, w_alusrca, w_alusrcb;
  logic [2:0]         w_alucontrol;
  logic [1:0]         w_immsrc;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = S_FETCH;
    w_aluop     = ALUOP_ADD;
    w_pcwrite   = 1'b0;
    w_memwrite  = 1'b0;
    w_irwrite   = 1'b0;
    w_regwrite  = 1'b0;
    w_illegal   = 1'b0;
    w_adrsrc    = 1'b0;
    w_resultsrc = 2'b00;
    w_alusrca   = 2'b00;
    w_alusrcb   = 2'b00;
    case (r_state)
      S_FETCH: begin
        w_next      = S_DECODE;
        w_irwrite   = 1'b1;
        w_alusrcb   = 2'b10;
        w_resultsrc = 2'b10;
        w_pcwrite   = 1'b1;
      end
      S_DECODE: begin
        // ALU precomputes the branch target OldPC + imm while decoding
        w_alusrca = 2'b01;
        w_alusrcb = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_BEQ:       w_next = S_BEQ;
          OP_JAL:       w_next = S_JAL;
          default:      w_illegal = 1'b1;
        endcase
      end
      S_MEMADR: begin
        w_next    = (bus.op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        w_alusrca = 2'b10;
        w_alusrcb = 2'b01;
      end
      S_MEMREAD: begin
        w_next   = S_MEMWB;
        w_adrsrc = 1'b1;
      end
      S_MEMWB: begin
        w_resultsrc = 2'b01;
        w_regwrite  = 1'b1;
      end
      S_MEMWRITE: begin
        w_adrsrc   = 1'b1;
        w_memwrite = 1'b1;
      end
      S_EXECR: begin
        w_next    = S_ALUWB;
        w_alusrca = 2'b10;
        w_aluop   = ALUOP_FUNCT;
      end
      S_EXECI: begin
        w_next    = S_ALUWB;
        w_alusrca = 2'b10;
        w_alusrcb = 2'b01;
        w_aluop   = ALUOP_FUNCT;
      end
      S_ALUWB: w_regwrite = 1'b1;
      S_BEQ: begin
        w_alusrca = 2'b10;
        w_aluop   = ALUOP_SUB;
        w_pcwrite = bus.zero;
      end
      S_JAL: begin
        w_next    = S_ALUWB;
        w_alusrca = 2'b01;
        w_alusrcb = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase
  end

  // Subtract only for R-type funct7b5; I-type bit 30 is immediate data
  always_comb begin
    w_alucontrol = 3'b000;
    if (w_aluop == ALUOP_SUB) begin
      w_alucontrol = 3'b001;
    end else if (w_aluop == ALUOP_FUNCT) begin
      case (bus.funct3)
        3'b000:  w_alucontrol = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
        3'b010:  w_alucontrol = 3'b101;
        3'b110:  w_alucontrol = 3'b011;
        3'b111:  w_alucontrol = 3'b010;
        default: w_alucontrol = 3'b000;
      endcase
    end
  end

  always_comb begin
    case (bus.op)
      OP_SW:   w_immsrc = 2'b01;
      OP_BEQ:  w_immsrc = 2'b10;
      OP_JAL:  w_immsrc = 2'b11;
      default: w_immsrc = 2'b00;
    endcase
  end

  assign bus.PCWrite    = w_pcwrite  & ~reset;
  assign bus.MemWrite   = w_memwrite & ~reset;
  assign bus.IRWrite    = w_irwrite  & ~reset;
  assign bus.RegWrite   = w_regwrite & ~reset;
  assign bus.illegal_op = w_illegal  & ~reset;
  assign bus.AdrSrc     = w_adrsrc;
  assign bus.ResultSrc  = w_resultsrc;
  assign bus.ALUSrcA    = w_alusrca;
  assign bus.ALUSrcB    = w_alusrcb;
  assign bus.ALUControl = w_alucontrol;
  assign bus.ImmSrc     = w_immsrc;
  assign state          = r_state;

endmodule
`default_nettype wire

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Control unit for the multicycle RISC-V core.
- Sequences the single shared ALU through fetch, decode, execute, memory and writeback, and drives the datapath mux selects and write enables.
- Decodes op/funct fields into the 3-bit ALUControl used by the ALU:
  - ALUControl[0] = 1 selects the two's-complement SrcB path.
- Sits between the instruction register and the datapath. Supports lw, sw, R-type, I-type ALU, beq, jal.

Parameters:
- STATE_W, 4, width of state register and debug state output

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- op  input  7  instruction opcode from instruction register
- funct3  input  3  instruction funct3
- funct7b5  input  1  instruction bit 30
- zero  input  1  ALU zero flag
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address select: 0=PC, 1=ALUOut
- MemWrite  output  1  data memory write enable
- IRWrite  output  1  instruction/OldPC register enable
- ResultSrc  output  2  00=ALUOut, 01=ReadData, 10=ALUResult
- ALUSrcA  output  2  00=PC, 01=OldPC, 10=rs1 data
- ALUSrcB  output  2  00=rs2 data, 01=ImmExt, 10=constant 4
- RegWrite  output  1  register file write enable
- ImmSrc  output  2  00=I, 01=S, 10=B, 11=J
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal_op  output  1  one-cycle pulse in DECODE for an unsupported opcode
- state  output  STATE_W  current state (debug)

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset:
  - Reset high at a rising edge loads FETCH.
  - While reset is high, PCWrite, IRWrite, MemWrite, RegWrite and illegal_op are forced to 0. Other outputs are don't-care.
  - The first cycle after reset deasserts is FETCH.
  - Reset mid-instruction aborts it; no further enables are asserted.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BEQ=9, JAL=10. Codes 11-15 go to FETCH on the next edge with all enables 0.
- Transitions:
  - FETCH->DECODE.
  - DECODE: op 0000011/0100011->MEMADR; 0110011->EXECR; 0010011->EXECI; 1100011->BEQ; 1101111->JAL; any other op->FETCH with illegal_op=1.
  - MEMADR: op 0000011->MEMREAD, else MEMWRITE.
  - MEMREAD->MEMWB->FETCH.
  - MEMWRITE->FETCH.
  - EXECR/EXECI/JAL->ALUWB->FETCH.
  - BEQ->FETCH.
- Moore outputs per state (unlisted signals are 0):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, PCWrite=1, ALUOp=add.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=add (branch target precompute).
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=add.
  - MEMREAD: ResultSrc=00, AdrSrc=1.
  - MEMWB: ResultSrc=01, RegWrite=1.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1.
  - EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=funct.
  - EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=funct.
  - ALUWB: ResultSrc=00, RegWrite=1.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=sub, ResultSrc=00, PCWrite=zero (only Mealy term).
  - JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1, ALUOp=add.
- ALU decode:
  - ALUOp=add->000; ALUOp=sub->001.
  - ALUOp=funct, by funct3:
    - 000: 001 if op[5]&funct7b5, else 000.
    - 010: 101.
    - 110: 011.
    - 111: 010.
    - Any other funct3: 000, with no error.
- ImmSrc (combinational from op, valid in every state): 0000011/0010011->00; 0100011->01; 1100011->10; 1101111->11; else 00.
- Latencies (cycles, FETCH to next FETCH): lw 5, sw 4, R 4, I 4, jal 4, beq 3, illegal 2.
- Exactly one of MemWrite/RegWrite/IRWrite is asserted per cycle, or none.

Test Plan:
- Reset 2 cycles in DECODE mid-lw, then release -> state=0, IRWrite=1, PCWrite=1, ALUSrcB=10, ALUControl=000; no RegWrite or MemWrite during reset.
- op=0000011 -> states 0,1,2,3,4,0; RegWrite=1 only in MEMWB with ResultSrc=01; ImmSrc=00.
- op=0100011 -> states 0,1,2,5,0; MemWrite=1 in state 5 only with AdrSrc=1; ImmSrc=01.
- op=0110011, funct3=000, funct7b5=1 -> ALUControl=001 in EXECR. Same with op=0010011 -> 000. funct3=010 -> 101. 110 -> 011. 111 -> 010.
- op=1100011 with zero=1 -> PCWrite=1 in BEQ, ALUControl=001. Repeat with zero=0 -> PCWrite=0; next state FETCH.
- op=1101111 -> states 0,1,10,8,0 with PCWrite=1 in JAL; op=1111111 -> illegal_op=1 one cycle in DECODE, then FETCH.
